// File: rtl/serializador_secuencia.sv
// Parallel-to-serial feeder for the 1101 detector: accepts a word on a
// valid/ready handshake and shifts it out MSB-first, each bit held BIT_CYCLES clocks.
module serializador_secuencia #(
   parameter int WIDTH      = 8,
   parameter int BIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dato_par,
   input  logic             cargar,
   output logic             listo,
   output logic             dato,
   output logic             activo,
   output logic             fin
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);
   localparam logic [CW-1:0] CYC_ONE  = CW'(1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [BW-1:0]    bit_cnt, bit_n;
   logic [CW-1:0]    cyc_cnt, cyc_n;
   logic             last;

   // The final clock of a word is the only SHIFT cycle that can take a new load.
   always_comb begin
      last  = (state == SHIFT) && (bit_cnt == '0) && (cyc_cnt == '0);
      listo = (state == IDLE) || last;
   end

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      bit_n   = bit_cnt;
      cyc_n   = cyc_cnt;
      case (state)
         IDLE: begin
            if (cargar) begin
               state_n = SHIFT;
               shreg_n = dato_par;
               bit_n   = BIT_LAST;
               cyc_n   = CYC_LAST;
            end
         end
         SHIFT: begin
            if (last) begin
               if (cargar) begin
                  shreg_n = dato_par;
                  bit_n   = BIT_LAST;
                  cyc_n   = CYC_LAST;
               end else begin
                  state_n = IDLE;
               end
            end else if (cyc_cnt == '0) begin
               shreg_n = {shreg[WIDTH-2:0], 1'b0};
               bit_n   = bit_cnt - BIT_ONE;
               cyc_n   = CYC_LAST;
            end else begin
               cyc_n   = cyc_cnt - CYC_ONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         cyc_cnt <= '0;
         dato    <= 1'b0;
         activo  <= 1'b0;
         fin     <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_n;
         cyc_cnt <= cyc_n;
         dato    <= (state_n == SHIFT) ? shreg_n[WIDTH-1] : 1'b0;
         activo  <= (state_n == SHIFT);
         fin     <= (state_n == SHIFT) && (bit_n == '0) && (cyc_n == '0);
      end
   end

endmodule

// File: tb/tb_serializador_secuencia.sv
// Directed bench for serializador_secuencia: reset, single word, back-to-back,
// ignored loads, asynchronous reset mid-word and the BIT_CYCLES=1 variant.
module tb_serializador_secuencia;

   logic       clk;
   logic       reset;
   logic [7:0] dato_par, dato_par1;
   logic       cargar, cargar1;
   logic       listo, dato, activo, fin;
   logic       listo1, dato1, activo1, fin1;
   int         checks;
   int         errors;

   serializador_secuencia #(.WIDTH(8), .BIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .dato_par(dato_par), .cargar(cargar),
      .listo(listo), .dato(dato), .activo(activo), .fin(fin)
   );

   serializador_secuencia #(.WIDTH(8), .BIT_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .dato_par(dato_par1), .cargar(cargar1),
      .listo(listo1), .dato(dato1), .activo(activo1), .fin(fin1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic start_load(input logic [7:0] w);
      @(negedge clk);
      cargar   = 1'b1;
      dato_par = w;
   endtask

   // Checks the 16 cycles of a word already accepted at the previous edge.
   task automatic check_word(input logic [7:0] w, input bit chain, input logic [7:0] nw,
                             input int inj, output logic [7:0] hits);
      logic [3:0] win;
      int         idx;
      win  = 4'b0000;
      hits = 8'h00;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         cargar = 1'b0;
         if (k == 3) dato_par = ~w;
         idx = 7 - (k - 1) / 2;
         checks++;
         if (dato !== w[idx]) begin
            errors++;
            $display("[TB] FAIL dato w=%h cycle %0d: got %b want %b", w, k, dato, w[idx]);
         end
         checks++;
         if (activo !== 1'b1) begin
            errors++;
            $display("[TB] FAIL activo w=%h cycle %0d: got %b want 1", w, k, activo);
         end
         checks++;
         if (fin !== (k == 16)) begin
            errors++;
            $display("[TB] FAIL fin w=%h cycle %0d: got %b want %b", w, k, fin, (k == 16));
         end
         checks++;
         if (listo !== (k == 16)) begin
            errors++;
            $display("[TB] FAIL listo w=%h cycle %0d: got %b want %b", w, k, listo, (k == 16));
         end
         if (k % 2 == 1) begin
            win = {win[2:0], dato};
            if (win == 4'b1101) hits[7 - idx] = 1'b1;
         end
         if (k == inj) begin
            cargar   = 1'b1;
            dato_par = 8'hFF;
         end
         if (k == 16 && chain) begin
            cargar   = 1'b1;
            dato_par = nw;
         end
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      checks++;
      if (dato !== 1'b0 || activo !== 1'b0 || fin !== 1'b0 || listo !== 1'b1) begin
         errors++;
         $display("[TB] FAIL idle_%s: got dato=%b activo=%b fin=%b listo=%b want 0 0 0 1",
                  tag, dato, activo, fin, listo);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if (dato !== 1'b0 || activo !== 1'b0 || fin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got dato=%b activo=%b fin=%b want 0 0 0",
                     dato, activo, fin);
         end
         @(negedge clk);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (listo !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_listo: got %b want 1", listo);
      end
   endtask

   task automatic test_single();
      logic [7:0] hits;
      start_load(8'b1101_1010);
      check_word(8'b1101_1010, 1'b0, 8'h00, 0, hits);
      checks++;
      if (hits !== 8'b0100_1000) begin
         errors++;
         $display("[TB] FAIL detect_1101: got hit mask %b want 01001000", hits);
      end
      check_idle("single");
   endtask

   task automatic test_back_to_back();
      logic [7:0] hits;
      start_load(8'h6D);
      check_word(8'h6D, 1'b1, 8'hD0, 0, hits);
      check_word(8'hD0, 1'b0, 8'h00, 0, hits);
      check_idle("b2b");
   endtask

   task automatic test_ignored_load();
      logic [7:0] hits;
      start_load(8'h00);
      check_word(8'h00, 1'b0, 8'h00, 5, hits);
      check_idle("ignored");
   endtask

   task automatic test_async_reset();
      logic [7:0] hits;
      logic       saw_fin;
      start_load(8'hB5);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         cargar = 1'b0;
      end
      checks++;
      if (dato !== 1'b1 || activo !== 1'b1) begin
         errors++;
         $display("[TB] FAIL prereset_cycle7: got dato=%b activo=%b want 1 1", dato, activo);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (dato !== 1'b0 || activo !== 1'b0 || fin !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: got dato=%b activo=%b fin=%b want 0 0 0",
                  dato, activo, fin);
      end
      saw_fin = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (fin !== 1'b0) saw_fin = 1'b1;
      end
      reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (fin !== 1'b0) saw_fin = 1'b1;
      end
      checks++;
      if (saw_fin !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_no_fin: got fin pulse 1 want 0");
      end
      checks++;
      if (listo !== 1'b1 || activo !== 1'b0) begin
         errors++;
         $display("[TB] FAIL after_release: got listo=%b activo=%b want 1 0", listo, activo);
      end
      start_load(8'h80);
      check_word(8'h80, 1'b0, 8'h00, 0, hits);
      check_idle("after_reset");
   endtask

   task automatic test_bit_cycles_one();
      logic [7:0] w;
      w = 8'hA5;
      @(negedge clk);
      cargar1   = 1'b1;
      dato_par1 = w;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         cargar1 = 1'b0;
         checks++;
         if (dato1 !== w[8 - k] || activo1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bc1_dato cycle %0d: got dato=%b activo=%b want %b 1",
                     k, dato1, activo1, w[8 - k]);
         end
         checks++;
         if (fin1 !== (k == 8) || listo1 !== (k == 8)) begin
            errors++;
            $display("[TB] FAIL bc1_fin cycle %0d: got fin=%b listo=%b want %b %b",
                     k, fin1, listo1, (k == 8), (k == 8));
         end
      end
      @(negedge clk);
      checks++;
      if (dato1 !== 1'b0 || activo1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bc1_idle: got dato=%b activo=%b want 0 0", dato1, activo1);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      cargar    = 1'b0;
      cargar1   = 1'b0;
      dato_par  = 8'h00;
      dato_par1 = 8'h00;
      test_reset();
      test_single();
      test_back_to_back();
      test_ignored_load();
      test_async_reset();
      test_bit_cycles_one();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
